// File: rtl/modelado_pkg.sv
// Shared definitions for the Q16.16 sequential multiplier: default widths,
// FSM state type, saturation limits and the sign/saturation helper.
package modelado_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;
    // Width of the product magnitude after the fractional shift.
    localparam int MAG_W     = 2 * DEF_WIDTH - DEF_FRAC;

    localparam logic [DEF_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [DEF_WIDTH-1:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic                 ovf;
        logic [DEF_WIDTH-1:0] val;
    } sat_t;

    // Apply the sign to a truncated magnitude and clamp to the Q16.16 range.
    // A zero magnitude is always +0, whatever the sign bit says.
    function automatic sat_t sat_q(input logic neg, input logic [MAG_W-1:0] mag);
        sat_t r;
        r.ovf = 1'b0;
        r.val = '0;
        if (mag == '0) begin
            r.val = '0;
        end else if (!neg) begin
            if (mag > MAG_W'(Q_MAX)) begin
                r.ovf = 1'b1;
                r.val = Q_MAX;
            end else begin
                r.val = mag[DEF_WIDTH-1:0];
            end
        end else begin
            // -2^31 is representable, so only magnitudes beyond it clamp.
            if (mag > MAG_W'(Q_MIN)) begin
                r.ovf = 1'b1;
                r.val = Q_MIN;
            end else begin
                r.val = ~mag[DEF_WIDTH-1:0] + 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/modelado_shift_add.sv
// Radix-2 shift-add datapath: unsigned magnitudes in, 2*WIDTH-bit product out.
// One multiplier bit is consumed per step, LSB first.
module modelado_shift_add
    import modelado_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    // The step that sees an all-ones counter is the final iteration.
    assign last = (cnt == '1);

    // Load operands, then shift multiplicand left / multiplier right per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/modelado_core.sv
// Sequential signed Q16.16 multiplier with start/done handshake.
// Sign-magnitude split on entry, shift-add on magnitudes, then truncate
// toward zero and saturate on exit.
module modelado_core
    import modelado_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    state_t             state, state_nx;
    logic               load, step, last;
    logic               neg_q;
    logic [WIDTH-1:0]   x_mag, y_mag;
    logic [2*WIDTH-1:0] acc;
    sat_t               sat;

    // Two's complement magnitude; 0x80000000 naturally becomes 2^31.
    assign x_mag = x[WIDTH-1] ? (~x + 1'b1) : x;
    assign y_mag = y[WIDTH-1] ? (~y + 1'b1) : y;

    assign sat  = sat_q(neg_q, acc[2*WIDTH-1:FRAC]);
    assign busy = (state != IDLE);

    modelado_shift_add #(.WIDTH(WIDTH)) u_shift_add (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .a     (x_mag),
        .b     (y_mag),
        .acc   (acc),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and datapath controls.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result sign is captured with the operands since x/y may move afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    neg_q <= 1'b0;
        else if (load) neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
    end

    // Registered outputs: result/overflow hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FINISH) begin
                result   <= sat.val;
                overflow <= sat.ovf;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modelado_core.sv
// Self-checking bench for modelado_core: a cycle-timed arithmetic model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_modelado_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        busy, done, overflow;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    modelado_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: exact signed product, divide by 2^16 truncating toward zero, clamp.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        q  = p / 64'sd65536;
        if (q > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
        else if (q < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else                           return {1'b0, q[31:0]};
    endfunction

    // Cycle model: an accepted start produces done 33 edges later.
    logic        m_busy, m_done, m_ovf;
    logic [31:0] m_res;
    logic [32:0] m_pend;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_ovf = 0; m_res = '0; m_cnt = 0; m_pend = '0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    {m_ovf, m_res} = m_pend;
                end
            end else if (start) begin
                m_busy = 1;
                m_cnt  = 33;
                m_pend = ref_mul(x, y);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (busy !== m_busy || done !== m_done || result !== m_res || overflow !== m_ovf) begin
            errors++;
            $display("FAIL cycle_model t=%0t busy=%b/%b done=%b/%b result=%h/%h ovf=%b/%b (got/expected)",
                     $time, busy, m_busy, done, m_done, result, m_res, overflow, m_ovf);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // One operation: start for one cycle, scramble inputs, wait for done and
    // check latency (34th negedge after the sampling edge) and the literal.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ovf);
        int n;
        @(posedge clk); #2;
        start = 1; x = a; y = b;
        @(posedge clk); #2;
        start = 0; x = $urandom; y = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        chk({name, "_latency"}, n, 34);
        chk({name, "_result"}, result, exp_res);
        chk({name, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
    endtask

    // Hand-computed pins for the model itself.
    initial begin
        chk("model_1p5x2", ref_mul(32'h0001_8000, 32'h0002_0000), {1'b0, 32'h0003_0000});
        chk("model_minsat", ref_mul(32'h8000_0000, 32'h0002_0000), {1'b1, 32'h8000_0000});
    end

    initial begin
        int n, gap, last_t, pulses;
        // Reset state, and start pulsed during reset must not launch anything.
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {29'b0, busy, done, overflow}, 32'h0);
        @(posedge clk); #2; start = 1; x = 32'h0001_0000; y = 32'h0001_0000;
        @(posedge clk); #2; start = 0;
        @(posedge clk); #2; rst_n = 1;
        @(negedge clk);
        chk("rst_no_op", {31'b0, busy}, 32'h0);

        run_op("mul_1p5_2",   32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 0);
        run_op("mul_neg1p5",  32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 0);
        run_op("mul_neg_neg", 32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000, 0);
        run_op("rnd_tiny",    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 0);
        run_op("rnd_negzero", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
        run_op("half_half",   32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 0);
        run_op("sat_pos",     32'h7FFF_FFFF, 32'h0002_0000, 32'h7FFF_FFFF, 1);
        run_op("sat_neg",     32'h8000_0000, 32'h0002_0000, 32'h8000_0000, 1);
        run_op("sat_min_neg", 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1);
        run_op("min_exact",   32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 0);

        // Start during BUSY with other operands is ignored.
        @(posedge clk); #2; start = 1; x = 32'h0003_0000; y = 32'h0002_0000;
        @(posedge clk); #2; start = 0;
        repeat (5) @(posedge clk);
        #2; start = 1; x = 32'h0007_0000; y = 32'h0007_0000;
        @(posedge clk); #2; start = 0;
        n = 6;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        chk("busy_start_latency", n, 34);
        chk("busy_start_result", result, 32'h0006_0000);

        // Start held high: done every 34 cycles.
        @(posedge clk); #2; start = 1; x = 32'h0002_0000; y = 32'h0002_0000;
        pulses = 0; last_t = 0;
        for (int c = 0; c < 120 && pulses < 3; c++) begin
            @(negedge clk);
            if (done) begin
                if (pulses > 0) begin
                    gap = c - last_t;
                    chk("b2b_gap", gap, 34);
                end
                last_t = c;
                pulses++;
            end
        end
        chk("b2b_pulses", pulses, 3);
        chk("b2b_result", result, 32'h0004_0000);
        @(posedge clk); #2; start = 0;
        repeat (40) @(posedge clk);

        // Reset mid-operation: outputs clear at once, no done afterwards.
        @(posedge clk); #2; start = 1; x = 32'h0005_0000; y = 32'h0003_0000;
        @(posedge clk); #2; start = 0;
        repeat (10) @(posedge clk);
        #2; rst_n = 0; #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_flags", {29'b0, busy, done, overflow}, 32'h0);
        repeat (2) @(posedge clk);
        #2; rst_n = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("midrst_no_done", n, 0);
        run_op("post_rst", 32'h0005_0000, 32'h0003_0000, 32'h000F_0000, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modelado_core.md
Name: modelado_core

Overview:
- Sequential signed fixed-point multiplier for the modelling datapath. Operands and result are Q16.16 two's complement.
- Takes two 32-bit operands `x` and `y` and produces a 32-bit saturated product `result` through a radix-2 shift-add state machine.
- Sits between the operand-loading logic and the result write-back, and uses a start/done handshake.

Parameters:
- `WIDTH`, default 32: operand and result width in bits.
- `FRAC`, default 16: number of fractional bits. The product is scaled down by 2^FRAC.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a multiply. Sampled only in IDLE.
- `x`, input, `WIDTH`: multiplicand, signed Q16.16. Captured when `start` is accepted.
- `y`, input, `WIDTH`: multiplier, signed Q16.16. Captured when `start` is accepted.
- `busy`, output, 1: high while an operation is in progress.
- `done`, output, 1: single-cycle pulse when `result` is updated.
- `result`, output, `WIDTH`: signed Q16.16 product, saturated. Held until the next completion.
- `overflow`, output, 1: high when the last `result` was saturated. Held with `result`.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `busy`, `done`, `overflow` = 0; `result` = 0x00000000; internal accumulators cleared.
  - Reset mid-operation aborts the operation with no `done`.
- FSM states: IDLE, BUSY, FINISH.
  - IDLE: `start`=1 at a rising edge captures |x| and |y| as unsigned 32-bit magnitudes, the sign `x[31]^y[31]`, clears the 64-bit accumulator and a 5-bit counter, then goes to BUSY.
  - BUSY: one multiplier bit per cycle, LSB first. If the current multiplier bit is 1, add the shifted multiplicand to the accumulator. After 32 iterations (counter wraps 31→0) go to FINISH.
  - FINISH: form the output, pulse `done`, return to IDLE.
- Latency: if `start` is sampled at edge k, `result`, `overflow` and `done` update at edge k+33. `done`=1 for exactly one cycle. `busy`=1 from edge k+1 through the cycle ending at edge k+33.
- `start` while BUSY or FINISH is ignored; no queueing.
- `start` held high continuously gives back-to-back operations. A new `start` may be accepted in the IDLE cycle right after `done`.
- Magnitude: 0x80000000 maps to the unsigned magnitude 2^31, so no special case is needed.
- Arithmetic:
  - P = |x|·|y| (64-bit unsigned); M = P >> 16 (48-bit), i.e. truncation of the magnitude, which rounds toward zero.
  - Positive result: if M > 0x7FFFFFFF then `result` = 0x7FFFFFFF and `overflow`=1.
  - Negative result: if M > 0x80000000 then `result` = 0x80000000 and `overflow`=1; otherwise `result` = −M.
  - A zero magnitude always yields `result` = 0, even when the sign bit is set.
- `x` and `y` may change freely after acceptance; only the captured values are used.

Decomposition:
- Shared package `modelado_pkg`:
  - `WIDTH`/`FRAC` defaults.
  - State enum `state_t` {IDLE, BUSY, FINISH}.
  - Saturation constants `Q_MAX` = 0x7FFFFFFF and `Q_MIN` = 0x80000000.
  - Function `sat_q` (sign, 48-bit magnitude → result, overflow flag).
- One natural sub-module: `modelado_shift_add`, the accumulator/counter datapath. The FSM and sign/saturation logic stay in `modelado_core`.

Test Plan:
- Reset checks:
  - Assert `rst_n`=0 → `result`=0x00000000, `done`=0, `busy`=0, `overflow`=0.
  - Pulse `start` during reset → no operation is started.
- Basic and signed products:
  - x=0x00018000 (1.5), y=0x00020000 (2.0), `start` at edge k → `done`=1 at edge k+33, `result`=0x00030000, `overflow`=0.
  - x=0xFFFE8000 (−1.5), y=0x00020000 → `result`=0xFFFD0000.
  - x=0xFFFF0000, y=0xFFFF0000 (−1·−1) → `result`=0x00010000.
- Rounding:
  - x=0x00000001, y=0x00000001 → 0x00000000.
  - x=0xFFFFFFFF, y=0x00000001 → 0x00000000 (toward zero).
  - x=0x00008000, y=0x00008000 (0.5·0.5) → 0x00004000.
- Saturation:
  - x=0x7FFFFFFF, y=0x00020000 → 0x7FFFFFFF, `overflow`=1.
  - x=0x80000000, y=0x00020000 → 0x80000000, `overflow`=1.
  - x=0x80000000, y=0xFFFF0000 → 0x7FFFFFFF, `overflow`=1.
  - x=0x80000000, y=0x00010000 → 0x80000000, `overflow`=0.
- Handshake:
  - Re-assert `start` with new operands during BUSY → ignored; the first result still arrives at k+33.
  - `start` held high → `done` pulses every 34 cycles.
- Reset mid-operation:
  - Drop `rst_n` at cycle k+10 → outputs go to 0 immediately and no `done` follows.
  - After release, a new operation completes normally.
